// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: merges per-stage stall requests, turns a
// committed exception or ERET into a registered multi-cycle flush with a redirect PC.
module pipe_stall_ctrl #(
  parameter int               NSTAGE        = 6,
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PC      = 32'h80000000,
  parameter int               FLUSH_CYCLES  = 1,
  parameter int               STALL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              global_stall,
  input  logic              exc_valid,
  input  logic              exc_is_eret,
  input  logic [WIDTH-1:0]  epc,
  input  logic [WIDTH-1:0]  ebase,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [WIDTH-1:0]  new_pc,
  output logic [WIDTH-1:0]  stall_cycles,
  output logic              timeout
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] new_pc_q, new_pc_d;
  logic [WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic             timeout_q, timeout_d;

  // A stall request from stage k freezes every older stage 0..k as well.
  always_comb begin
    stall = '0;
    if (!rst && !exc_valid && state_q == RUN) begin
      if (global_stall) begin
        stall = '1;
      end else begin
        for (int k = 0; k < NSTAGE; k++) begin
          stall[k] = |(stallreq >> k);
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    flush_d        = flush_q;
    new_pc_d       = new_pc_q;
    stall_cycles_d = stall_cycles_q;
    run_cnt_d      = run_cnt_q;
    timeout_d      = timeout_q;

    if (state_q == RUN) begin
      if (exc_valid) begin
        state_d  = FLUSH;
        fcnt_d   = '0;
        flush_d  = 1'b1;
        new_pc_d = exc_is_eret ? epc : ebase;
      end
    end else begin
      // Exceptions arriving while flushing are dropped, not queued.
      if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
        state_d = RUN;
        fcnt_d  = '0;
        flush_d = 1'b0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    if (|stall) begin
      stall_cycles_d = stall_cycles_q + WIDTH'(1);
      if (run_cnt_q != RW'(STALL_TIMEOUT)) begin
        run_cnt_d = run_cnt_q + RW'(1);
      end
      if (STALL_TIMEOUT != 0 && (run_cnt_q + RW'(1)) == RW'(STALL_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else begin
      run_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      fcnt_q         <= '0;
      flush_q        <= 1'b0;
      new_pc_q       <= RESET_PC;
      stall_cycles_q <= '0;
      run_cnt_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
      run_cnt_q      <= run_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int NS = 6;
  localparam int W  = 32;
  localparam int FC = 3;
  localparam int TO = 4;
  localparam logic [W-1:0] RPC = 32'h80000000;

  logic          clk;
  logic          rst;
  logic [NS-1:0] stallreq;
  logic          global_stall;
  logic          exc_valid;
  logic          exc_is_eret;
  logic [W-1:0]  epc;
  logic [W-1:0]  ebase;
  logic [NS-1:0] stall;
  logic          flush;
  logic [W-1:0]  new_pc;
  logic [W-1:0]  stall_cycles;
  logic          timeout;

  pipe_stall_ctrl #(
    .NSTAGE(NS), .WIDTH(W), .RESET_PC(RPC), .FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .global_stall(global_stall),
    .exc_valid(exc_valid), .exc_is_eret(exc_is_eret), .epc(epc), .ebase(ebase),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cycles(stall_cycles),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: remaining flush cycles, captured PC, counters.
  int           m_flush_left = 0;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_sc;
  int           m_run = 0;
  bit           m_to  = 1'b0;
  bit           m_valid = 1'b0;
  logic [NS-1:0] es;
  int           hi;

  initial begin
    forever begin
      @(negedge clk);
      es = '0;
      if (!rst && !exc_valid && m_flush_left == 0) begin
        if (global_stall) begin
          es = '1;
        end else begin
          hi = -1;
          for (int k = 0; k < NS; k++) if (stallreq[k]) hi = k;
          for (int k = 0; k <= hi; k++) es[k] = 1'b1;
        end
      end
      if (m_valid) begin
        chk("m_stall", stall, es);
        chk("m_flush", flush, (m_flush_left > 0));
        chk("m_new_pc", new_pc, m_pc);
        chk("m_stall_cycles", stall_cycles, m_sc);
        chk("m_timeout", timeout, m_to);
      end
      if (rst) begin
        m_flush_left = 0;
        m_pc  = RPC;
        m_sc  = '0;
        m_run = 0;
        m_to  = 1'b0;
        m_valid = 1'b1;
      end else begin
        if (m_flush_left > 0) begin
          m_flush_left--;
        end else if (exc_valid) begin
          m_flush_left = FC;
          m_pc = exc_is_eret ? epc : ebase;
        end
        if (es != '0) begin
          m_sc = m_sc + 1;
          if (m_run < TO) m_run++;
          if (TO != 0 && m_run >= TO) m_to = 1'b1;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq = 6'b111111; global_stall = 1'b0;
    exc_valid = 1'b1; exc_is_eret = 1'b0; epc = '0; ebase = '0;
    #1;
    chk("rst_stall", stall, 6'b000000);
    tick();
    tick();
    rst = 1'b0; exc_valid = 1'b0; stallreq = '0;
    #1;
    chk("rst_flush", flush, 1'b0);
    chk("rst_new_pc", new_pc, 32'h80000000);
    chk("rst_stall_cycles", stall_cycles, 32'd0);

    tick(); stallreq = 6'b000100; #1;
    chk("stall_000100", stall, 6'b000111);
    tick(); stallreq = 6'b010100; #1;
    chk("stall_010100", stall, 6'b011111);
    tick(); stallreq = 6'b000000; global_stall = 1'b1; #1;
    chk("stall_global", stall, 6'b111111);
    tick(); global_stall = 1'b0; #1;
    chk("stall_cycles_3", stall_cycles, 32'd3);
    chk("stall_idle", stall, 6'b000000);

    tick(); ebase = 32'h80001000; stallreq = 6'b001000; exc_valid = 1'b1; #1;
    chk("exc_stall0", stall, 6'b000000);
    for (int i = 0; i < FC; i++) begin
      tick(); exc_valid = 1'b0; #1;
      chk("exc_flush", flush, 1'b1);
      chk("exc_new_pc", new_pc, 32'h80001000);
      chk("exc_flush_stall0", stall, 6'b000000);
    end
    tick(); #1;
    chk("exc_run_flush0", flush, 1'b0);
    chk("exc_req_reappears", stall, 6'b001111);
    tick(); stallreq = '0;

    tick(); exc_valid = 1'b1; exc_is_eret = 1'b1; epc = 32'h80000040;
    for (int i = 0; i < FC; i++) begin
      tick(); exc_valid = 1'b1; exc_is_eret = 1'b0; ebase = 32'h80002000; #1;
      chk("eret_flush", flush, 1'b1);
      chk("eret_new_pc", new_pc, 32'h80000040);
    end
    tick(); exc_valid = 1'b0; #1;
    chk("eret_done_flush0", flush, 1'b0);
    chk("eret_pc_held", new_pc, 32'h80000040);

    for (int i = 0; i < 3; i++) begin tick(); stallreq = 6'b000001; end
    tick(); stallreq = '0;
    for (int i = 0; i < 4; i++) begin
      tick(); stallreq = 6'b000001; #1;
      chk("wd_before", timeout, 1'b0);
    end
    tick(); stallreq = '0; #1;
    chk("wd_fired", timeout, 1'b1);
    tick(); #1;
    chk("wd_sticky", timeout, 1'b1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("wd_cleared", timeout, 1'b0);

    tick(); exc_valid = 1'b1; ebase = 32'h80003000;
    tick(); exc_valid = 1'b0; #1;
    chk("mid_flush1", flush, 1'b1);
    chk("mid_pc", new_pc, 32'h80003000);
    tick(); rst = 1'b1; #1;
    chk("mid_flush2", flush, 1'b1);
    tick(); rst = 1'b0; #1;
    chk("mid_rst_flush0", flush, 1'b0);
    chk("mid_rst_pc", new_pc, 32'h80000000);
    tick(); #1;
    chk("mid_rst_run", flush, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      tick();
      rst          = ($urandom_range(0, 99) == 0);
      stallreq     = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      global_stall = ($urandom_range(0, 9) == 0);
      exc_valid    = ($urandom_range(0, 11) == 0);
      exc_is_eret  = $urandom_range(0, 1) == 1;
      epc          = $urandom;
      ebase        = $urandom;
    end
    tick(); rst = 1'b0; exc_valid = 1'b0; stallreq = '0; global_stall = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Parametrised pipeline stall/flush controller for the N-stage CPU pipeline. It merges per-stage stall requests into a contiguous stall vector. It turns a committed exception (or ERET) into a registered, multi-cycle flush with a stable redirect PC. It also tracks stall statistics and a stuck-pipeline watchdog. It sits beside the pipeline registers and drives their stall/flush inputs and the PC register's redirect.

## Interface
Parameters:
- NSTAGE, 6, number of pipeline stages; stall bit 0 = PC, bit NSTAGE-1 = last stage
- WIDTH, 32, address/data width
- RESET_PC, 32'h80000000, redirect PC presented during and after reset
- FLUSH_CYCLES, 1, cycles flush stays asserted per exception (>=1)
- STALL_TIMEOUT, 1024, consecutive stalled cycles before watchdog fires; 0 disables it

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stallreq  in  NSTAGE  bit k = stage k requests stall of stages 0..k
- global_stall  in  1  stall every stage (instruction-fetch bus busy)
- exc_valid  in  1  committed exception/ERET this cycle
- exc_is_eret  in  1  qualifies exc_valid: 1 = ERET
- epc  in  WIDTH  CP0 EPC, latest value
- ebase  in  WIDTH  exception entry address
- stall  out  NSTAGE  stall vector, combinational
- flush  out  1  flush all pipeline registers, registered
- new_pc  out  WIDTH  redirect PC, registered, valid while flush=1
- stall_cycles  out  WIDTH  count of cycles with stall!=0, wraps
- timeout  out  1  sticky watchdog flag

## Operation
- FSM states: RUN, FLUSH. A 1-cycle-per-state counter fcnt counts 0..FLUSH_CYCLES-1.
- RUN with exc_valid=1 at an edge: go to FLUSH and set fcnt=0.
  - Capture new_pc = exc_is_eret ? epc : ebase.
  - flush goes to 1.
- FLUSH: fcnt increments each edge. At fcnt==FLUSH_CYCLES-1, the next edge goes to RUN and flush goes to 0.
  - exc_valid is ignored in FLUSH; there is no queueing.
- new_pc holds its last captured value until the next capture.
- stall, combinational:
  - 0 if exc_valid=1 or state==FLUSH (exception has priority).
  - Else all ones if global_stall=1.
  - Else, with h = the highest set index of stallreq, stall = bits 0..h set. 0 if stallreq==0.
  - Example, NSTAGE=6, stallreq=6'b010100 gives stall=6'b011111.
- stall_cycles: +1 on every edge where stall!=0; modulo 2^WIDTH.
- Watchdog:
  - run_cnt (width clog2(STALL_TIMEOUT+1)) increments on each edge with stall!=0 and clears on an edge with stall==0.
  - When the increment makes run_cnt==STALL_TIMEOUT, timeout is set. It stays set until rst; run_cnt saturates.
  - With STALL_TIMEOUT=0, timeout stays 0.
- Reset (rst sampled high at an edge): state=RUN, fcnt=0, flush=0, new_pc=RESET_PC, stall_cycles=0, run_cnt=0, timeout=0.
  - Reset overrides everything, including mid-flush.
  - While rst is high, stall is forced 0.

## Timing
- exc_valid high at cycle n: stall=0 in cycle n. flush=1 and new_pc valid in cycles n+1..n+FLUSH_CYCLES. flush=0 at n+FLUSH_CYCLES+1.
- The earliest next accepted exception is cycle n+FLUSH_CYCLES+1.
- stall has zero latency from stallreq/global_stall/exc_valid. All other outputs change only at clock edges.
- A stall request that persists through a flush reappears on stall in the first RUN cycle.
- stall_cycles and run_cnt count stall as observed in the cycle before the edge.

## Test plan
- Reset: hold rst 2 cycles with stallreq=6'b111111 and exc_valid=1 -> stall=0, flush=0, new_pc=32'h80000000, stall_cycles=0 after release.
- Stall priority (NSTAGE=6): stallreq=6'b000100 -> stall=6'b000111; stallreq=6'b010100 -> 6'b011111; global_stall=1 -> 6'b111111. Hold for 3 cycles -> stall_cycles=3.
- Exception: ebase=32'h80001000, exc_valid=1 for one cycle with stallreq=6'b001000 -> stall=0 that cycle; flush=1 for FLUSH_CYCLES=3 cycles with new_pc=32'h80001000; then RUN.
- ERET in flush: exc_is_eret=1 with epc=32'h80000040 -> new_pc=32'h80000040. A second exc_valid during the flush window is ignored and new_pc is unchanged.
- Watchdog (STALL_TIMEOUT=4): 3 stalled cycles, 1 free cycle, then 4 stalled -> timeout rises only after the 4th consecutive stalled edge; it stays 1 after stalls stop, until rst.
- Mid-flush reset: rst during the 2nd flush cycle -> next cycle flush=0, new_pc=RESET_PC, state RUN.
